bin_to_bcd_seq: RTL and testbench

Sequential double-dabble converter that turns an unsigned binary value into the four packed BCD digits the seven-segment driver consumes on its `bcd_data_ip[15:0]` input. It sits directly upstream of the display driver, in the 100 MHz domain. Each conversion is started by a single pulse, takes a fixed number of cycles and ends with a one-cycle `done` pulse. Out-of-range values produce an all-`F` pattern, which the driver shows as blank digits.

---
 rtl/bin_to_bcd_seq.sv | 115 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: unsigned binary in, four packed BCD digits out, done pulse BIN_WIDTH+1 cycles after start.
// A start that arrives while busy is dropped; values above 9999 produce 16'hFFFF with overflow set.
module bin_to_bcd_seq #(
    parameter int BIN_WIDTH = 14
) (
    input  logic                 clk_100mhz,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin_in,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [15:0]          bcd_data_op
);
    localparam int CW = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [BIN_WIDTH-1:0]   bin_q, bin_d;
    logic [15:0]            scr_q, scr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   ovf_pend_q, ovf_pend_d;
    logic                   done_q, done_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            bcd_q, bcd_d;

    logic [15:0]            adj;
    logic [16+BIN_WIDTH-1:0] cat;
    logic [16:0]            bin_ext;
    logic                   ovf_in;

    // Compared at 17 bits so narrow widths fold to a constant 0.
    assign bin_ext = 17'(bin_in);
    assign ovf_in  = (bin_ext > 17'd9999);

    always_comb begin
        adj = scr_q;
        for (int i = 0; i < 4; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        cat = {adj, bin_q} << 1;

        state_d    = state_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        bcd_d      = bcd_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d      = bin_in;
                    scr_d      = 16'h0000;
                    cnt_d      = CW'(BIN_WIDTH);
                    ovf_pend_d = ovf_in;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = cat[16+BIN_WIDTH-1:BIN_WIDTH];
                bin_d = cat[BIN_WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bcd_d      = ovf_pend_q ? 16'hFFFF : scr_q;
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            bcd_q      <= bcd_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign overflow    = overflow_q;
    assign bcd_data_op = bcd_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboarded bench for bin_to_bcd_seq: directed vectors queue expected results, a monitor checks each done.
module tb_bin_to_bcd_seq;
    logic        clk_100mhz = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] bcd_data_op;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] exp_bcd[$];
    logic        exp_ovf[$];
    int          exp_cyc[$];

    bin_to_bcd_seq #(.BIN_WIDTH(14)) dut (
        .clk_100mhz  (clk_100mhz),
        .reset       (reset),
        .start       (start),
        .bin_in      (bin_in),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .bcd_data_op (bcd_data_op)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    always @(posedge clk_100mhz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_100mhz) begin
        #1;
        if (done === 1'b1) begin
            check("busy_with_done", 32'(busy), 32'd0);
            if (exp_bcd.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [15:0] eb;
                logic        eo;
                int          ec;
                eb = exp_bcd.pop_front();
                eo = exp_ovf.pop_front();
                ec = exp_cyc.pop_front();
                check("bcd_data_op", 32'(bcd_data_op), 32'(eb));
                check("overflow", 32'(overflow), 32'(eo));
                check("latency", 32'(cyc - ec), 32'd15);
            end
        end
    end

    task automatic do_start(input logic [13:0] v, input logic [15:0] eb, input logic eo, input bit push);
        @(negedge clk_100mhz);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk_100mhz);
        start  = 1'b0;
        if (push) begin
            exp_bcd.push_back(eb);
            exp_ovf.push_back(eo);
            exp_cyc.push_back(cyc);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_bcd.size() != 0 && n < 40) begin
            @(negedge clk_100mhz);
            n++;
        end
        if (exp_bcd.size() != 0) begin
            check("done_timeout", 32'(exp_bcd.size()), 32'd0);
            exp_bcd.delete();
            exp_ovf.delete();
            exp_cyc.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_bcd"}, 32'(bcd_data_op), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
        $fatal(1);
    end

    initial begin
        int a;
        int n;
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (2) @(negedge clk_100mhz);
        check_reset_outputs("reset_init");
        reset = 1'b0;

        // Basic conversions with hold check
        do_start(14'd0, 16'h0000, 1'b0, 1'b1);
        wait_idle();
        do_start(14'd1234, 16'h1234, 1'b0, 1'b1);
        wait_idle();
        repeat (5) @(negedge clk_100mhz);
        check("hold_1234", 32'(bcd_data_op), 32'h1234);
        do_start(14'd9999, 16'h9999, 1'b0, 1'b1);
        repeat (6) @(negedge clk_100mhz);
        check("no_intermediate", 32'(bcd_data_op), 32'h1234);
        check("busy_mid", 32'(busy), 32'd1);
        wait_idle();

        // Asynchronous reset between edges clears outputs immediately
        @(negedge clk_100mhz);
        #1 reset = 1'b1;
        #1 check_reset_outputs("reset_async");
        @(negedge clk_100mhz);
        reset = 1'b0;

        // Overflow and recovery
        do_start(14'd10000, 16'hFFFF, 1'b1, 1'b1);
        wait_idle();
        do_start(14'd16383, 16'hFFFF, 1'b1, 1'b1);
        wait_idle();
        do_start(14'd42, 16'h0042, 1'b0, 1'b1);
        wait_idle();

        // Busy rejection: second start five cycles in is dropped
        do_start(14'd5678, 16'h5678, 1'b0, 1'b1);
        repeat (4) @(negedge clk_100mhz);
        start  = 1'b1;
        bin_in = 14'd1111;
        @(negedge clk_100mhz);
        start  = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk_100mhz);
        check("reject_result", 32'(bcd_data_op), 32'h5678);

        // Back-to-back with start held; second accept coincides with done
        @(negedge clk_100mhz);
        start  = 1'b1;
        bin_in = 14'd7;
        @(negedge clk_100mhz);
        a = cyc;
        exp_bcd.push_back(16'h0007);
        exp_ovf.push_back(1'b0);
        exp_cyc.push_back(a);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk_100mhz);
            n++;
        end
        check("b2b_first_done_seen", 32'(done), 32'd1);
        bin_in = 14'd8;
        exp_bcd.push_back(16'h0008);
        exp_ovf.push_back(1'b0);
        exp_cyc.push_back(a + 16);
        @(negedge clk_100mhz);
        start = 1'b0;
        check("b2b_accept_on_done", 32'(busy), 32'd1);
        wait_idle();
        repeat (3) @(negedge clk_100mhz);

        // Mid-conversion reset aborts with no done
        do_start(14'd4321, 16'h0000, 1'b0, 1'b0);
        repeat (4) @(negedge clk_100mhz);
        #1 reset = 1'b1;
        @(negedge clk_100mhz);
        reset = 1'b0;
        repeat (20) @(negedge clk_100mhz);
        check("midreset_bcd", 32'(bcd_data_op), 32'h0000);
        check("midreset_busy", 32'(busy), 32'd0);
        do_start(14'd4321, 16'h4321, 1'b0, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk_100mhz);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
